// File: rtl/div_pkg.sv
// Shared types and constants for the 16/8 sequential divider.
package div_pkg;

    localparam int DW_D = 8;
    localparam int DW_N = 2 * DW_D;

    // Quotient reported for divide-by-zero and quotient overflow
    localparam logic [DW_D-1:0] Q_SAT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and try subtracting.
// Latency: combinational.
// Backpressure: none; purely combinational.
module div_step
    import div_pkg::*;
(
    input  logic [DW_D-1:0] rem,
    input  logic            bit_in,
    input  logic [DW_D-1:0] d,
    output logic [DW_D-1:0] rem_next,
    output logic            qbit
);

    logic [DW_D:0]   t;
    logic [DW_D-1:0] diff;

    assign t    = {rem, bit_in};
    // rem < d on entry, so t - d always fits in DW_D bits and mod-2^DW_D arithmetic is exact
    assign diff = t[DW_D-1:0] - d;
    assign qbit = (t >= {1'b0, d});

    assign rem_next = qbit ? diff : t[DW_D-1:0];

endmodule

// File: rtl/seq_div_16_8.sv
// Sequential restoring divider, 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Latency: 1 cycle for divide-by-zero/overflow, 9 cycles (load + 8 steps) otherwise.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one division in flight.
module seq_div_16_8
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] IN1,
    input  logic [DW_D-1:0] IN2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_D-1:0] Q,
    output logic [DW_D-1:0] R,
    output logic            div_zero,
    output logic            overflow
);

    state_t          state, state_nxt;
    logic [2:0]      cnt;
    logic [DW_D-1:0] rem;
    logic [DW_D-1:0] low;
    logic [DW_D-1:0] quo;
    logic [DW_D-1:0] dvs;
    logic [DW_D-1:0] rem_next;
    logic            qbit;
    logic            accept;
    logic            is_zero;
    logic            is_ovf;
    logic            last_step;

    div_step u_step (
        .rem      (rem),
        .bit_in   (low[DW_D-1]),
        .d        (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Handshake outputs decode from state only, so no input-to-output combinational path
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign accept    = in_valid && in_ready;
    assign is_zero   = (IN2 == '0);
    assign is_ovf    = (IN1[DW_N-1:DW_D] >= IN2);
    assign last_step = (cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (is_zero || is_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            low      <= '0;
            quo      <= '0;
            dvs      <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (is_zero) begin
                Q        <= Q_SAT;
                R        <= '0;
                div_zero <= 1'b1;
                overflow <= 1'b0;
            end else if (is_ovf) begin
                Q        <= Q_SAT;
                R        <= '0;
                div_zero <= 1'b0;
                overflow <= 1'b1;
            end else begin
                rem      <= IN1[DW_N-1:DW_D];
                low      <= IN1[DW_D-1:0];
                dvs      <= IN2;
                quo      <= '0;
                cnt      <= '0;
                div_zero <= 1'b0;
                overflow <= 1'b0;
            end
        end else if (state == CALC) begin
            rem <= rem_next;
            low <= {low[DW_D-2:0], 1'b0};
            quo <= {quo[DW_D-2:0], qbit};
            cnt <= cnt + 3'd1;
            // Output registers only update on completion so Q/R stay stable outside DONE too
            if (last_step) begin
                Q <= {quo[DW_D-2:0], qbit};
                R <= rem_next;
            end
        end
    end

endmodule
